execute_unit: RTL and testbench

Multi-cycle RV32I integer execute stage that sits directly downstream of the instruction decoder and register-file read, and upstream of data-memory access and write-back. It accepts one decoded instruction per start pulse and computes the ALU result, the write-back enable and the next PC. For loads and stores it also computes the effective address. Shifts are iterative, one bit per cycle; every other operation completes in one cycle.

---
 rtl/execute_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_execute_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit.sv
// execute_unit: RV32I integer execute stage. One instruction per start pulse;
// shifts iterate one bit per cycle, all other operations finish in one cycle.
module execute_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm_i,
  input  logic [31:0] imm_s,
  input  logic [31:0] imm_b,
  input  logic [31:0] imm_u,
  input  logic [31:0] imm_j,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        rd_wen,
  output logic [31:0] next_pc,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        shl_q, shl_d;
  logic        sra_q, sra_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        rd_wen_q, rd_wen_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [2:0]  mem_funct3_q, mem_funct3_d;
  logic        illegal_q, illegal_d;

  // decoded view of the instruction currently presented on the inputs
  logic [31:0] ex_result, ex_next_pc, op_b, pc_plus4;
  logic        ex_wen, ex_mread, ex_mwrite, ex_illegal, ex_is_shift, ex_taken;
  logic [4:0]  ex_shamt;

  // Combinational decode and single-cycle ALU for the presented instruction
  always_comb begin
    pc_plus4    = pc + 32'd4;
    op_b        = (opcode == OPC_OP) ? rs2_data : imm_i;
    ex_shamt    = op_b[4:0];
    ex_result   = 32'd0;
    ex_next_pc  = pc_plus4;
    ex_wen      = 1'b0;
    ex_mread    = 1'b0;
    ex_mwrite   = 1'b0;
    ex_illegal  = 1'b0;
    ex_is_shift = 1'b0;
    ex_taken    = 1'b0;
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        ex_wen = 1'b1;
        case (funct3)
          3'b000: begin
            // only register-register ADD can become SUB
            if ((opcode == OPC_OP) && funct7[5]) begin
              ex_result = rs1_data - op_b;
            end else begin
              ex_result = rs1_data + op_b;
            end
          end
          3'b010:  ex_result = ($signed(rs1_data) < $signed(op_b)) ? 32'd1 : 32'd0;
          3'b011:  ex_result = (rs1_data < op_b) ? 32'd1 : 32'd0;
          3'b100:  ex_result = rs1_data ^ op_b;
          3'b110:  ex_result = rs1_data | op_b;
          3'b111:  ex_result = rs1_data & op_b;
          3'b001, 3'b101: begin
            // working value starts as rs1; shamt==0 leaves it unchanged
            ex_result   = rs1_data;
            ex_is_shift = 1'b1;
          end
          default: ex_result = 32'd0;
        endcase
      end
      OPC_LUI: begin
        ex_result = imm_u;
        ex_wen    = 1'b1;
      end
      OPC_AUIPC: begin
        ex_result = pc + imm_u;
        ex_wen    = 1'b1;
      end
      OPC_JAL: begin
        ex_result  = pc_plus4;
        ex_next_pc = pc + imm_j;
        ex_wen     = 1'b1;
      end
      OPC_JALR: begin
        ex_result  = pc_plus4;
        ex_next_pc = (rs1_data + imm_i) & ~32'd1;
        ex_wen     = 1'b1;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  ex_taken = (rs1_data == rs2_data);
          3'b001:  ex_taken = (rs1_data != rs2_data);
          3'b100:  ex_taken = ($signed(rs1_data) < $signed(rs2_data));
          3'b101:  ex_taken = ($signed(rs1_data) >= $signed(rs2_data));
          3'b110:  ex_taken = (rs1_data < rs2_data);
          3'b111:  ex_taken = (rs1_data >= rs2_data);
          default: begin
            ex_taken   = 1'b0;
            ex_illegal = 1'b1;
          end
        endcase
        ex_next_pc = ex_taken ? (pc + imm_b) : pc_plus4;
      end
      OPC_LOAD: begin
        ex_result = rs1_data + imm_i;
        ex_mread  = 1'b1;
      end
      OPC_STORE: begin
        ex_result = rs1_data + imm_s;
        ex_mwrite = 1'b1;
      end
      default: ex_illegal = 1'b1;
    endcase
  end

  // Next-state logic: accept a new instruction in IDLE, step the shifter in SHIFT
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shl_d        = shl_q;
    sra_d        = sra_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    result_d     = result_q;
    rd_out_d     = rd_out_q;
    rd_wen_d     = rd_wen_q;
    next_pc_d    = next_pc_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_funct3_d = mem_funct3_q;
    illegal_d    = illegal_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          result_d     = ex_result;
          rd_out_d     = rd;
          rd_wen_d     = ex_wen & (rd != 5'd0);
          next_pc_d    = ex_next_pc;
          mem_read_d   = ex_mread;
          mem_write_d  = ex_mwrite;
          mem_funct3_d = funct3;
          illegal_d    = ex_illegal;
          shl_d        = (funct3 == 3'b001);
          sra_d        = funct7[5];
          if (ex_is_shift && (ex_shamt != 5'd0)) begin
            state_d = SHIFT;
            count_d = ex_shamt;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      SHIFT: begin
        if (shl_q) begin
          result_d = {result_q[30:0], 1'b0};
        end else if (sra_q) begin
          result_d = {result_q[31], result_q[31:1]};
        end else begin
          result_d = {1'b0, result_q[31:1]};
        end
        count_d = count_q - 5'd1;
        if (count_q == 5'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 5'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= 5'd0;
      shl_q        <= 1'b0;
      sra_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= 32'd0;
      rd_out_q     <= 5'd0;
      rd_wen_q     <= 1'b0;
      next_pc_q    <= RESET_PC;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_funct3_q <= 3'd0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shl_q        <= shl_d;
      sra_q        <= sra_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      rd_out_q     <= rd_out_d;
      rd_wen_q     <= rd_wen_d;
      next_pc_q    <= next_pc_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_funct3_q <= mem_funct3_d;
      illegal_q    <= illegal_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign rd_out     = rd_out_q;
  assign rd_wen     = rd_wen_q;
  assign next_pc    = next_pc_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_funct3 = mem_funct3_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed vectors with hand-computed expectations for execute_unit.
module tb_execute_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc;
  logic        busy, done, rd_wen, mem_read, mem_write, illegal;
  logic [31:0] result, next_pc;
  logic [4:0]  rd_out;
  logic [2:0]  mem_funct3;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;
  logic saw_done;

  execute_unit #(.RESET_PC(32'h0000_1000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm_i(imm_i), .imm_s(imm_s), .imm_b(imm_b), .imm_u(imm_u), .imm_j(imm_j),
    .pc(pc), .busy(busy), .done(done), .result(result), .rd_out(rd_out),
    .rd_wen(rd_wen), .next_pc(next_pc), .mem_read(mem_read),
    .mem_write(mem_write), .mem_funct3(mem_funct3), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // pulse start for one rising edge; returns 1ns after that edge
  task automatic issue();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // wait for done with a bounded cycle budget; cycles counts edges waited
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while ((done !== 1'b1) && (n < budget)) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},    {31'd0, busy},      32'd0);
    check({tag, "_done"},    {31'd0, done},      32'd0);
    check({tag, "_result"},  result,             32'd0);
    check({tag, "_rd_out"},  {27'd0, rd_out},    32'd0);
    check({tag, "_rd_wen"},  {31'd0, rd_wen},    32'd0);
    check({tag, "_next_pc"}, next_pc,            32'h0000_1000);
    check({tag, "_mrd"},     {31'd0, mem_read},  32'd0);
    check({tag, "_mwr"},     {31'd0, mem_write}, 32'd0);
    check({tag, "_mf3"},     {29'd0, mem_funct3}, 32'd0);
    check({tag, "_illegal"}, {31'd0, illegal},   32'd0);
  endtask

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rdi, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ii);
    opcode = opc; funct3 = f3; funct7 = f7; rd = rdi;
    rs1_data = a; rs2_data = b; imm_i = ii;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; rd = 5'd0;
    rs1_data = 32'd0; rs2_data = 32'd0;
    imm_i = 32'd0; imm_s = 32'd0; imm_b = 32'd0; imm_u = 32'd0; imm_j = 32'd0;
    pc = 32'h0000_1000;

    // asynchronous reset between clock edges
    #2 reset = 1'b0;
    #1 check_reset_values("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);

    // ADD overflow wraps
    pc = 32'h0000_1000;
    set_op(7'b0110011, 3'b000, 7'b0000000, 5'd5, 32'h7FFF_FFFF, 32'd1, 32'd0);
    issue();
    check("add_done",   {31'd0, done},   32'd1);
    check("add_result", result,          32'h8000_0000);
    check("add_wen",    {31'd0, rd_wen}, 32'd1);
    check("add_rd",     {27'd0, rd_out}, 32'd5);
    check("add_npc",    next_pc,         32'h0000_1004);
    // SUB back-to-back while done is high
    set_op(7'b0110011, 3'b000, 7'b0100000, 5'd6, 32'd0, 32'd1, 32'd0);
    issue();
    check("sub_done",   {31'd0, done}, 32'd1);
    check("sub_result", result,        32'hFFFF_FFFF);
    // ADD with rd=0 never writes back
    set_op(7'b0110011, 3'b000, 7'b0000000, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0);
    issue();
    check("add_rd0_wen", {31'd0, rd_wen}, 32'd0);
    check("add_rd0_res", result,          32'h8000_0000);
    @(posedge clk);
    #1;
    check("done_width", {31'd0, done}, 32'd0);
    check("hold_result", result, 32'h8000_0000);

    // ADDI with funct7[5] set still adds; SLTI signed, ANDI
    set_op(7'b0010011, 3'b000, 7'b0100000, 5'd3, 32'd10, 32'd0, 32'hFFFF_FFFE);
    issue();
    check("addi_res", result, 32'd8);
    set_op(7'b0010011, 3'b010, 7'b0000000, 5'd3, 32'hFFFF_FFFB, 32'd0, 32'd1);
    issue();
    check("slti_res", result, 32'd1);
    set_op(7'b0110011, 3'b011, 7'b0000000, 5'd3, 32'hFFFF_FFFB, 32'd1, 32'd0);
    issue();
    check("sltu_res", result, 32'd0);
    set_op(7'b0010011, 3'b111, 7'b0000000, 5'd3, 32'hF0F0_1234, 32'd0, 32'h0000_0FF0);
    issue();
    check("andi_res", result, 32'h0000_0230);

    // SRAI by 31
    set_op(7'b0010011, 3'b101, 7'b0100000, 5'd7, 32'h8000_0000, 32'd0, 32'h0000_041F);
    issue();
    check("srai_busy",   {31'd0, busy}, 32'd1);
    check("srai_nodone", {31'd0, done}, 32'd0);
    wait_done(40, cycles);
    check("srai_cycles", cycles, 32'd31);
    check("srai_result", result, 32'hFFFF_FFFF);
    check("srai_busy_end", {31'd0, busy}, 32'd0);

    // SRL by 31 with a stray start mid-shift
    set_op(7'b0110011, 3'b101, 7'b0000000, 5'd7, 32'h8000_0000, 32'd31, 32'd0);
    issue();
    repeat (3) @(posedge clk);
    set_op(7'b0110011, 3'b000, 7'b0000000, 5'd9, 32'd0, 32'd0, 32'd0);
    issue();
    check("stray_busy", {31'd0, busy}, 32'd1);
    wait_done(40, cycles);
    check("srl_cycles", cycles, 32'd27);
    check("srl_result", result, 32'd1);
    check("srl_rd",     {27'd0, rd_out}, 32'd7);

    // SLL with shamt 0 completes in one cycle, value unchanged
    set_op(7'b0110011, 3'b001, 7'b0000000, 5'd4, 32'hDEAD_BEEF, 32'd0, 32'd0);
    issue();
    check("sll0_done",   {31'd0, done}, 32'd1);
    check("sll0_result", result,        32'hDEAD_BEEF);

    // branches
    pc = 32'h0000_1010; imm_b = 32'hFFFF_FFF0;
    set_op(7'b1100011, 3'b100, 7'b0000000, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue();
    check("blt_npc", next_pc,         32'h0000_1000);
    check("blt_wen", {31'd0, rd_wen}, 32'd0);
    set_op(7'b1100011, 3'b110, 7'b0000000, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue();
    check("bltu_npc", next_pc,         32'h0000_1014);
    check("bltu_wen", {31'd0, rd_wen}, 32'd0);
    set_op(7'b1100011, 3'b010, 7'b0000000, 5'd5, 32'd1, 32'd1, 32'd0);
    issue();
    check("b010_ill", {31'd0, illegal}, 32'd1);
    check("b010_npc", next_pc,          32'h0000_1014);

    // jumps, memory, illegal opcode
    pc = 32'h0000_1020;
    set_op(7'b1100111, 3'b000, 7'b0000000, 5'd1, 32'h0000_2003, 32'd0, 32'd4);
    issue();
    check("jalr_npc", next_pc, 32'h0000_2006);
    check("jalr_res", result,  32'h0000_1024);
    check("jalr_wen", {31'd0, rd_wen}, 32'd1);
    imm_j = 32'h0000_0100;
    set_op(7'b1101111, 3'b000, 7'b0000000, 5'd1, 32'd0, 32'd0, 32'd0);
    issue();
    check("jal_npc", next_pc, 32'h0000_1120);
    check("jal_res", result,  32'h0000_1024);
    set_op(7'b0000011, 3'b010, 7'b0000000, 5'd8, 32'h0000_2000, 32'd0, 32'hFFFF_FFFC);
    issue();
    check("lw_res", result, 32'h0000_1FFC);
    check("lw_mrd", {31'd0, mem_read}, 32'd1);
    check("lw_wen", {31'd0, rd_wen},   32'd0);
    check("lw_mf3", {29'd0, mem_funct3}, 32'd2);
    imm_s = 32'h0000_0010;
    set_op(7'b0100011, 3'b000, 7'b0000000, 5'd0, 32'h0000_2000, 32'd0, 32'd0);
    issue();
    check("sb_res", result, 32'h0000_2010);
    check("sb_mwr", {31'd0, mem_write}, 32'd1);
    check("sb_mrd", {31'd0, mem_read},  32'd0);
    imm_u = 32'h1234_5000;
    set_op(7'b0010111, 3'b000, 7'b0000000, 5'd2, 32'd0, 32'd0, 32'd0);
    issue();
    check("auipc_res", result, 32'h1234_6020);
    set_op(7'h7F, 3'b000, 7'b0000000, 5'd3, 32'h5, 32'h6, 32'd0);
    issue();
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_npc",  next_pc,          32'h0000_1024);
    check("ill_res",  result,           32'd0);
    check("ill_wen",  {31'd0, rd_wen},  32'd0);

    // reset in the middle of a 20-bit SLL
    set_op(7'b0110011, 3'b001, 7'b0000000, 5'd6, 32'd1, 32'd20, 32'd0);
    issue();
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", {31'd0, saw_done}, 32'd0);
    check("midrst_busy",    {31'd0, busy},     32'd0);
    pc = 32'h0000_1000;
    set_op(7'b0110011, 3'b000, 7'b0000000, 5'd5, 32'd2, 32'd3, 32'd0);
    issue();
    check("after_rst_done", {31'd0, done}, 32'd1);
    check("after_rst_res",  result,        32'd5);
    check("after_rst_npc",  next_pc,       32'h0000_1004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
